// File: rtl/sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter
//
// Shares a single downstream sram-like port between the instruction-fetch
// master (inst_*) and the data-access master (data_*).
//
// Address phase:
//   - The data master has priority. If the inst master has been waiting
//     through STARVE_MAX consecutive data grants, the inst master is forced
//     through on the next grant.
//   - If the downstream does not accept a request in the cycle it is
//     presented, the grant is frozen to that master (HOLD_I / HOLD_D) until
//     mem_addr_ok. The grant is released early if the held master drops
//     its request (pipeline flush).
//   - Every accepted address phase pushes the id of its master
//     (0 = inst, 1 = data) into a small in-order FIFO.
//   - No request is presented while DEPTH transactions are outstanding.
//
// Data phase:
//   - The downstream returns responses in order. Each mem_data_ok pops the
//     FIFO head and is steered to the master that issued that transaction.
//     mem_rdata is broadcast to both masters unmodified.
//   - A mem_data_ok that arrives with nothing outstanding is dropped.
//
// Ports:
//   aclk, aresetn                 clock, synchronous active-low reset
//   inst_req .. inst_wdata        inst master request and fields
//   inst_addr_ok / inst_data_ok   inst handshakes, inst_rdata read data
//   data_req .. data_wdata        data master request and fields
//   data_addr_ok / data_data_ok   data handshakes, data_rdata read data
//   mem_req .. mem_wdata          downstream request and fields
//   mem_addr_ok / mem_data_ok     downstream handshakes, mem_rdata
//
// Parameters:
//   DEPTH       max outstanding transactions, power of 2, 2..16
//   STARVE_MAX  data grants tolerated while inst waits, 1..255
// -----------------------------------------------------------------------------
module sram_like_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  // ---------------------------------------------------------------------------
  // Widths and constants
  // ---------------------------------------------------------------------------
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;   // FIFO pointer width
  localparam int CW = $clog2(DEPTH + 1);                  // occupancy width
  localparam int SW = $clog2(STARVE_MAX + 1);             // starvation counter

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD_I = 2'd1,
    ST_HOLD_D = 2'd2
  } state_t;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [SW-1:0]   r_starve;
  logic            r_fifo_id [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic w_full;
  logic w_starved;
  logic w_sel_data;   // 1: data master owns the port this cycle
  logic w_src_req;    // request of whichever master may present this cycle
  logic w_mem_req;
  logic w_push;
  logic w_pop;
  logic w_head_id;

  // Full is taken from the registered count only, so a pop in the same
  // cycle never opens a slot early.
  assign w_full    = (r_count == DEPTH_C);
  assign w_starved = inst_req && (r_starve == STARVE_C);

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case/if can leave it unassigned and infer a latch.
  always_comb begin
    w_sel_data = 1'b0;
    w_src_req  = 1'b0;
    case (r_state)
      ST_HOLD_I: begin
        w_sel_data = 1'b0;
        w_src_req  = inst_req;
      end
      ST_HOLD_D: begin
        w_sel_data = 1'b1;
        w_src_req  = data_req;
      end
      default: begin
        // Data wins unless inst has waited through STARVE_MAX data grants.
        w_sel_data = data_req && !w_starved;
        w_src_req  = inst_req || data_req;
      end
    endcase
  end

  // Reset gates every handshake so nothing leaks out while aresetn is low.
  assign w_mem_req = aresetn && w_src_req && !w_full;
  assign w_push    = w_mem_req && mem_addr_ok;
  assign w_pop     = aresetn && mem_data_ok && (r_count != '0);
  assign w_head_id = r_fifo_id[r_rd_ptr];

  // ---------------------------------------------------------------------------
  // Downstream request mux; fields read as zero when nothing is presented.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req   = w_mem_req;
    mem_wr    = 1'b0;
    mem_size  = 2'b00;
    mem_wstrb = 4'b0000;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (w_mem_req) begin
      if (w_sel_data) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Upstream handshakes
  // ---------------------------------------------------------------------------
  assign inst_addr_ok = w_push && !w_sel_data;
  assign data_addr_ok = w_push &&  w_sel_data;

  assign inst_data_ok = w_pop && (w_head_id == ID_INST);
  assign data_data_ok = w_pop && (w_head_id == ID_DATA);

  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // ---------------------------------------------------------------------------
  // Order FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: the id storage carries no reset. An entry is only read after it has
  // been written, and resetting the pointers/count is enough to discard any
  // stale contents; resetting the array would only add reset fan-out.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_fifo_id[r_wr_ptr] <= w_sel_data ? ID_DATA : ID_INST;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy, starvation counter and grant FSM
  // ---------------------------------------------------------------------------
  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_starve <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;   // idle, or push and pop cancel out
      endcase

      // Counts data grants that inst had to watch; any cycle inst is not
      // asking, or an inst grant, wipes the history.
      if (!inst_req) begin
        r_starve <= '0;
      end else if (w_push && !w_sel_data) begin
        r_starve <= '0;
      end else if (w_push && w_sel_data && (r_starve != STARVE_C)) begin
        r_starve <= r_starve + SW'(1);
      end

      case (r_state)
        ST_IDLE: begin
          // A presented but unaccepted request freezes the grant.
          if (w_mem_req && !mem_addr_ok) begin
            r_state <= w_sel_data ? ST_HOLD_D : ST_HOLD_I;
          end
        end
        ST_HOLD_I: begin
          // Release on acceptance, or when the master withdraws (flush).
          if (!inst_req || w_push) r_state <= ST_IDLE;
        end
        ST_HOLD_D: begin
          if (!data_req || w_push) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_like_arbiter
//
// Self-checking bench for sram_like_arbiter (DEPTH=4, STARVE_MAX=8).
// A behavioural reference model (queue of outstanding master ids, held-grant
// owner, starvation tally) predicts every output each cycle. Directed
// sequences cover the scenarios of interest; a randomized phase follows.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_sram_like_arbiter;

  localparam int DEPTH = 4;
  localparam int SMAX  = 8;

  logic        aclk = 1'b0;
  logic        aresetn;

  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  always #5 aclk = ~aclk;

  sram_like_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  bit outstanding[$];   // ids of accepted, unanswered transactions (1 = data)
  int held  = -1;       // master the port is frozen to, -1 = none
  int starve = 0;       // data grants seen while inst kept asking

  // Per-cycle results for directed checks and the stimulus generator.
  int          m_grant;     // model: master granted this cycle, -1 none
  int          o_grant;     // observed: 0 inst_addr_ok, 1 data_addr_ok, -1 none
  int          o_dok;       // observed: 0 inst_data_ok, 1 data_data_ok, -1 none
  logic        o_req;
  logic [31:0] o_addr;
  logic [31:0] o_rdata;

  // One clock cycle: predict and compare outputs, then advance the model.
  task automatic tick();
    int  cand;
    bit  req, acc, pop, head, cand_req;
    #1;
    if (held < 0) begin
      if (data_req && !(inst_req && starve == SMAX)) cand = 1;
      else if (inst_req)                             cand = 0;
      else                                           cand = -1;
      cand_req = (cand >= 0);
    end else begin
      cand     = held;
      cand_req = (held == 1) ? data_req : inst_req;
    end
    req  = aresetn && cand_req && (outstanding.size() < DEPTH);
    acc  = req && mem_addr_ok;
    pop  = aresetn && mem_data_ok && (outstanding.size() > 0);
    head = pop ? outstanding[0] : 1'b0;

    check("mem_req", mem_req, req);
    if (req) begin
      check("mem_addr",  mem_addr,  cand == 1 ? data_addr  : inst_addr);
      check("mem_wdata", mem_wdata, cand == 1 ? data_wdata : inst_wdata);
      check("mem_ctrl",  {mem_wr, mem_size, mem_wstrb},
            cand == 1 ? {data_wr, data_size, data_wstrb} : {inst_wr, inst_size, inst_wstrb});
    end else if (!inst_req && !data_req) begin
      check("mem_addr_idle", mem_addr, 32'h0);
    end
    check("inst_addr_ok", inst_addr_ok, acc && cand == 0);
    check("data_addr_ok", data_addr_ok, acc && cand == 1);
    check("inst_data_ok", inst_data_ok, pop && !head);
    check("data_data_ok", data_data_ok, pop &&  head);
    check("inst_rdata",   inst_rdata,   mem_rdata);
    check("data_rdata",   data_rdata,   mem_rdata);

    m_grant = acc ? cand : -1;
    o_grant = inst_addr_ok ? 0 : (data_addr_ok ? 1 : -1);
    o_dok   = inst_data_ok ? 0 : (data_data_ok ? 1 : -1);
    o_req   = mem_req;
    o_addr  = mem_addr;
    o_rdata = inst_data_ok ? inst_rdata : data_rdata;

    @(posedge aclk);
    if (!aresetn) begin
      outstanding.delete();
      held   = -1;
      starve = 0;
    end else begin
      if (pop) void'(outstanding.pop_front());
      if (acc) outstanding.push_back(bit'(cand));
      if (held < 0) begin
        if (req && !mem_addr_ok) held = cand;
      end else if (!cand_req || acc) begin
        held = -1;
      end
      if (!inst_req)                   starve = 0;
      else if (acc && cand == 0)       starve = 0;
      else if (acc && cand == 1 && starve < SMAX) starve++;
    end
    @(negedge aclk);
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
    inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  task automatic rand_inst();
    inst_wr = $urandom_range(0, 1); inst_size = 2'($urandom_range(0, 2));
    inst_wstrb = 4'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
  endtask

  task automatic rand_data();
    data_wr = $urandom_range(0, 1); data_size = 2'($urandom_range(0, 2));
    data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
  endtask

  initial begin
    idle_inputs();
    aresetn = 1'b0;
    @(negedge aclk);

    // ---- Reset state: handshakes low while reset held with requests up ----
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    tick();
    check("reset_mem_req", o_req, 1'b0);
    check("reset_grant", 32'(o_grant), 32'(-1));
    check("reset_dok", 32'(o_dok), 32'(-1));
    do_reset();

    // ---- Single inst read ----
    inst_req = 1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1;
    tick();
    check("single_grant", 32'(o_grant), 32'd0);
    check("single_addr", o_addr, 32'hBFC0_0000);
    idle_inputs();
    tick(); tick();
    mem_data_ok = 1; mem_rdata = 32'h3C08_0001;
    tick();
    check("single_dok", 32'(o_dok), 32'd0);
    check("single_rdata", o_rdata, 32'h3C08_0001);
    idle_inputs();
    tick();
    check("single_quiet", 32'(o_dok), 32'(-1));

    // ---- Priority and hold ----
    do_reset();
    inst_req = 1; inst_addr = 32'h0000_1000;
    data_req = 1; data_addr = 32'h0000_2000;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("prio_addr", o_addr, 32'h0000_2000);
    end
    mem_addr_ok = 1;
    tick();
    check("prio_grant", 32'(o_grant), 32'd1);
    data_req = 0; mem_addr_ok = 0;
    tick();
    check("hold_i_first", o_addr, 32'h0000_1000);
    data_req = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold_i_addr", o_addr, 32'h0000_1000);
    end
    mem_addr_ok = 1;
    tick();
    check("hold_i_grant", 32'(o_grant), 32'd0);

    // ---- Ordering ----
    do_reset();
    mem_addr_ok = 1;
    inst_req = 1; inst_addr = 32'h100; tick();
    inst_req = 0; data_req = 1; data_addr = 32'h200; tick();
    data_req = 0; inst_req = 1; inst_addr = 32'h104; tick();
    idle_inputs();
    mem_data_ok = 1;
    mem_rdata = 32'hAAAA_0001; tick();
    check("order_a_id", 32'(o_dok), 32'd0);
    check("order_a_data", o_rdata, 32'hAAAA_0001);
    mem_rdata = 32'hBBBB_0002; tick();
    check("order_b_id", 32'(o_dok), 32'd1);
    check("order_b_data", o_rdata, 32'hBBBB_0002);
    mem_rdata = 32'hCCCC_0003; tick();
    check("order_c_id", 32'(o_dok), 32'd0);
    check("order_c_data", o_rdata, 32'hCCCC_0003);

    // ---- Full ----
    do_reset();
    inst_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < DEPTH; i++) begin
      inst_addr = 32'h4000 + 32'(i * 4);
      tick();
      check("fill_grant", 32'(o_grant), 32'd0);
    end
    tick();
    check("full_no_req", o_req, 1'b0);
    mem_data_ok = 1;
    tick();
    check("full_pop_no_req", o_req, 1'b0);
    tick();                                   // push + pop, count stays 3
    check("pushpop_req", o_req, 1'b1);
    mem_data_ok = 0;
    tick();                                   // count 3 -> 4
    check("refill_req", o_req, 1'b1);
    tick();
    check("refull_no_req", o_req, 1'b0);

    // ---- Starvation ----
    do_reset();
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    for (int k = 0; k < 2 * (SMAX + 1) + 1; k++) begin
      tick();
      check("starve_grant", 32'(o_grant), (k % (SMAX + 1) == SMAX) ? 32'd0 : 32'd1);
    end

    // ---- Reset mid-flight ----
    do_reset();
    inst_req = 1; mem_addr_ok = 1;
    tick(); tick();
    aresetn = 0;
    tick();
    aresetn = 1; idle_inputs(); mem_data_ok = 1;
    tick();
    check("rst_drop_dok", 32'(o_dok), 32'(-1));
    mem_data_ok = 0; data_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check("rst_empty_grant", 32'(o_grant), 32'd1);
    end
    tick();
    check("rst_refull", o_req, 1'b0);

    // ---- Randomized phase against the model ----
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (m_grant == 0 || !inst_req) begin
        inst_req = ($urandom_range(0, 99) < 40);
        rand_inst();
      end else if ($urandom_range(0, 99) < 5) begin
        inst_req = 0;
      end
      if (m_grant == 1 || !data_req) begin
        data_req = ($urandom_range(0, 99) < 55);
        rand_data();
      end else if ($urandom_range(0, 99) < 5) begin
        data_req = 0;
      end
      mem_addr_ok = $urandom_range(0, 1);
      mem_data_ok = ($urandom_range(0, 99) < 40);
      mem_rdata   = $urandom;
      aresetn     = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
Shares one downstream sram-like port between the instruction-fetch and data-access sram-like masters of the pipeline. It sits between the IF/EXE/MEM stages and the AXI bridge. It grants address phases with data priority plus an anti-starvation guard, holds the grant stable across an unacknowledged request, and tracks up to DEPTH outstanding transactions. Each in-order data_ok/rdata is routed back to the master that issued it.

Parameters:
DEPTH, 4, max outstanding transactions; order-FIFO depth, power of 2, 2..16
STARVE_MAX, 8, consecutive data grants while inst is waiting before inst is forced a grant; 1..255

Ports:
aclk  in  1  clock, all state on rising edge
aresetn  in  1  synchronous active-low reset
inst_req / inst_wr  in  1 / 1  inst master request, write flag
inst_size / inst_wstrb  in  2 / 4  inst size, byte strobe
inst_addr / inst_wdata  in  32 / 32  inst address, write data
inst_addr_ok / inst_data_ok  out  1 / 1  inst handshakes
inst_rdata  out  32  inst read data
data_req / data_wr / data_size / data_wstrb / data_addr / data_wdata  in  1/1/2/4/32/32  data master, same meaning
data_addr_ok / data_data_ok  out  1 / 1  data handshakes
data_rdata  out  32  data read data
mem_req / mem_wr / mem_size / mem_wstrb / mem_addr / mem_wdata  out  1/1/2/4/32/32  downstream request
mem_addr_ok / mem_data_ok  in  1 / 1  downstream handshakes
mem_rdata  in  32  downstream read data

Behaviour:
- Reset (aresetn low at posedge): FSM=IDLE, FIFO empty (count=0, rd/wr ptr=0), starve_cnt=0. While aresetn is low, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok are forced to 0. A reset mid-transaction drops all outstanding entries; data_ok after reset with an empty FIFO is dropped.
- full = (count==DEPTH), registered count. No request is presented when full, even if a pop occurs in the same cycle.
- FSM states IDLE, HOLD_I, HOLD_D:
  - In IDLE, sel = data if data_req && !(inst_req && starve_cnt==STARVE_MAX); otherwise inst if inst_req.
  - mem_req = (inst_req|data_req) && !full. The mem_* fields are muxed from sel, and are 0 when there is no request.
  - IDLE -> HOLD_x when mem_req && !mem_addr_ok. The grant is frozen to x and sel must not change until addr_ok.
  - HOLD_x: mem_req = x_req && !full, fields taken from x. On mem_addr_ok go to IDLE.
  - If x drops req while in HOLD_x (flush), go to IDLE next cycle with no push.
- addr handshake: on mem_req && mem_addr_ok, the granted master sees x_addr_ok=1 combinationally in the same cycle; the other master sees 0. Push source id (0=inst, 1=data) into the FIFO.
- Return: mem_data_ok with count>0 pops the FIFO head and asserts inst_data_ok or data_data_ok for the head id in the same cycle. mem_rdata is broadcast to inst_rdata and data_rdata unmodified.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance. Pointers wrap mod DEPTH.
- Writes occupy a FIFO entry and get data_ok like reads.
- starve_cnt:
  - increments (saturating at STARVE_MAX) on each accepted data grant while inst_req=1;
  - clears on an accepted inst grant or when inst_req=0.
- Latency: 0 cycles request->mem_req; 0 cycles mem_data_ok->x_data_ok. No internal data buffering.

Test Plan:
- Single inst read: inst_req addr 0xBFC00000, mem_addr_ok same cycle, mem_data_ok 3 cycles later with rdata 0x3C080001 -> inst_addr_ok 1 cycle, inst_data_ok 1 cycle with rdata 0x3C080001; data_* handshakes remain 0.
- Priority and hold: inst_req and data_req both high with mem_addr_ok low for 2 cycles -> mem_addr = data_addr throughout. Drop data_req, grant inst, then raise data_req while inst is held with mem_addr_ok low -> mem_addr stays inst_addr until its addr_ok.
- Ordering: grants inst, data, inst, then 3 mem_data_ok pulses with rdata A, B, C -> inst_data_ok(A), data_data_ok(B), inst_data_ok(C).
- Full: DEPTH=4, 4 accepted with no returns -> mem_req=0. A mem_data_ok alone in that cycle still leaves mem_req=0. The next cycle mem_req=1, and push+pop in one cycle keeps count=3.
- Starvation: data_req and inst_req held high, mem_addr_ok always 1, STARVE_MAX=8 -> 8 data grants, 1 inst grant, then data resumes.
- Reset mid-flight: 2 outstanding, pull aresetn low 1 cycle, then mem_data_ok -> no x_data_ok asserted, count=0, state IDLE.
